// File: rtl/start_pkg.sv
`default_nettype none
// ============================================================================
// Module      : start_pkg
// Description : Shared definitions for the periodic start-pulse interface.
//               Both the start generator and start_monitor import this
//               package, so the prescale default and the expected-interval
//               arithmetic are defined once and cannot drift apart.
//               Contents:
//                 c_PRESCALE_SHIFT_DEFAULT - log2 of clocks per period unit
//                 state_t                  - monitor FSM state encoding
//                 expected_interval()      - user_period << shift
// Revision    : 1.0 - initial release
// ============================================================================
package start_pkg;

    // log2 of clocks per user_period unit; generator and monitor must agree.
    localparam int c_PRESCALE_SHIFT_DEFAULT = 23;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // disabled; counter parked at 0
        ST_ACQUIRE = 2'd1,   // waiting for a reference edge
        ST_TRACK   = 2'd2    // measuring edge-to-edge intervals
    } state_t;

    // Expected interval in clocks. Evaluated in 64 bits so the caller can
    // truncate to its own counter width; the counter width is chosen so
    // that user_period (8 bits) shifted by the prescale always fits.
    function automatic logic [63:0] expected_interval(
        input logic [7:0] user_period,
        input int         shift
    );
        logic [63:0] v_period;
        v_period = {56'd0, user_period};
        return v_period << shift;
    endfunction

endpackage : start_pkg
`default_nettype wire

// File: rtl/start_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : start_monitor_if
// Description : Start-pulse / slow-control bundle between the start strobe
//               source plus slow control (master) and start_monitor (slave).
//               Signals:
//                 in_start      strobe, synchronous to clk
//                 user_period   programmed period in prescale units
//                 enable        monitor enable
//                 err_clear     one-cycle pulse clearing sticky errors
//                 start_seen    one-cycle pulse per detected rising edge
//                 locked        LOCK_N consecutive good intervals
//                 period_err    sticky out-of-tolerance flag
//                 missing_err   sticky missing-pulse flag
//                 last_interval most recent measured interval (clocks)
//                 start_count   wrapping count of edges while enabled
// Revision    : 1.0 - initial release
// ============================================================================
interface start_monitor_if #(
    parameter int CNT_W = 32
);
    logic             in_start;
    logic [7:0]       user_period;
    logic             enable;
    logic             err_clear;
    logic             start_seen;
    logic             locked;
    logic             period_err;
    logic             missing_err;
    logic [CNT_W-1:0] last_interval;
    logic [15:0]      start_count;

    // Strobe source / slow control side.
    modport master (
        output in_start,
        output user_period,
        output enable,
        output err_clear,
        input  start_seen,
        input  locked,
        input  period_err,
        input  missing_err,
        input  last_interval,
        input  start_count
    );

    // Monitor side.
    modport slave (
        input  in_start,
        input  user_period,
        input  enable,
        input  err_clear,
        output start_seen,
        output locked,
        output period_err,
        output missing_err,
        output last_interval,
        output start_count
    );

endinterface : start_monitor_if
`default_nettype wire

// File: rtl/start_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : start_edge_detect
// Description : Rising-edge detector for a signal already synchronous to clk.
//               The history register resets to 1 so a level that is already
//               high when reset releases is not reported as an edge.
//               Ports:
//                 clk    system clock
//                 rst    asynchronous, active-high reset
//                 i_sig  input level
//                 o_rise combinational pulse, high in the edge cycle
// Revision    : 1.0 - initial release
// ============================================================================
module start_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule : start_edge_detect
`default_nettype wire

// File: rtl/start_monitor.sv
`default_nettype none
// ============================================================================
// Module      : start_monitor
// Description : Receiving end of the periodic start-pulse interface. Detects
//               rising edges of the start strobe, measures the edge-to-edge
//               interval and checks it against
//               E = user_period << PRESCALE_SHIFT with a tolerance of +/-TOL
//               clocks. Reports lock, the last interval, and sticky
//               period / missing-pulse errors. All outputs are registered.
//               Parameters:
//                 PRESCALE_SHIFT log2 clocks per user_period unit
//                 CNT_W          interval counter width (>= PRESCALE_SHIFT+9)
//                 TOL            accepted deviation in clocks
//                 LOCK_N         consecutive good intervals to assert locked
//               Ports:
//                 clk, rst       clock, asynchronous active-high reset
//                 bus            start_monitor_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module start_monitor
    import start_pkg::*;
#(
    parameter int PRESCALE_SHIFT = c_PRESCALE_SHIFT_DEFAULT,
    parameter int CNT_W          = 32,
    parameter int TOL            = 2,
    parameter int LOCK_N         = 4
) (
    input  logic           clk,
    input  logic           rst,
    start_monitor_if.slave bus
);

    localparam int                    c_CONSEC_W   = $clog2(LOCK_N + 1);
    localparam logic [c_CONSEC_W-1:0] c_LOCK_N     = c_CONSEC_W'(LOCK_N);
    localparam logic [c_CONSEC_W-1:0] c_CONSEC_ONE = c_CONSEC_W'(1);
    localparam logic [CNT_W-1:0]      c_TOL        = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]      c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX    = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_n;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_n;
    logic [c_CONSEC_W-1:0] r_consec;
    logic [c_CONSEC_W-1:0] w_consec_n;
    logic                  r_locked;
    logic                  w_locked_n;
    logic                  r_period_err;
    logic                  w_period_err_n;
    logic                  r_missing_err;
    logic                  w_missing_err_n;
    logic [CNT_W-1:0]      r_last_interval;
    logic [CNT_W-1:0]      w_last_interval_n;
    logic [15:0]           r_start_count;
    logic [15:0]           w_start_count_n;
    logic                  r_start_seen;
    logic [7:0]            r_user_period;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_edge;
    logic [CNT_W-1:0]      w_cnt_inc;      // saturating cnt+1, equals I on an edge
    logic [CNT_W-1:0]      w_expected;     // E
    logic [CNT_W-1:0]      w_diff;         // |I - E|
    logic                  w_good;
    logic                  w_timeout;
    logic                  w_check_on;
    logic                  w_up_changed;
    logic [c_CONSEC_W-1:0] w_consec_inc;
    logic                  w_period_set;
    logic                  w_missing_set;

    start_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (bus.in_start),
        .o_rise (w_edge)
    );

    always_comb begin
        w_expected   = CNT_W'(expected_interval(bus.user_period, PRESCALE_SHIFT));
        w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
        w_diff       = (w_cnt_inc >= w_expected) ? (w_cnt_inc - w_expected)
                                                 : (w_expected - w_cnt_inc);
        w_good       = (w_diff <= c_TOL);
        // cnt+1 == E+TOL+1 is the first clock at which an edge would already
        // be out of tolerance, so the gap is declared missing there.
        w_timeout    = (r_cnt == (w_expected + c_TOL));
        w_check_on   = (bus.user_period != 8'd0);
        w_up_changed = (bus.user_period != r_user_period);
        w_consec_inc = (r_consec >= c_LOCK_N) ? c_LOCK_N : (r_consec + c_CONSEC_ONE);
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n         = r_state;
        w_cnt_n           = w_edge ? '0 : w_cnt_inc;
        w_consec_n        = r_consec;
        w_locked_n        = r_locked;
        w_last_interval_n = r_last_interval;
        w_start_count_n   = r_start_count;
        w_period_set      = 1'b0;
        w_missing_set     = 1'b0;

        if (!bus.enable) begin
            // Disable wins from any state; sticky errors, count and last
            // interval are left untouched.
            w_state_n  = ST_IDLE;
            w_cnt_n    = '0;
            w_consec_n = '0;
            w_locked_n = 1'b0;
        end else begin
            if (w_edge && (r_state != ST_IDLE)) begin
                w_start_count_n = r_start_count + 16'd1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    w_state_n = ST_ACQUIRE;
                end

                ST_ACQUIRE: begin
                    // The first edge only provides a reference; cnt is
                    // already cleared by the default above.
                    if (w_edge) begin
                        w_state_n = ST_TRACK;
                    end
                end

                ST_TRACK: begin
                    if (w_up_changed) begin
                        // New programmed period: restart acquisition quietly.
                        w_state_n  = ST_ACQUIRE;
                        w_consec_n = '0;
                        w_locked_n = 1'b0;
                    end else if (w_edge) begin
                        w_last_interval_n = w_cnt_inc;
                        if (!w_check_on) begin
                            w_consec_n = '0;
                            w_locked_n = 1'b0;
                        end else if (w_good) begin
                            w_consec_n = w_consec_inc;
                            if (w_consec_inc == c_LOCK_N) begin
                                w_locked_n = 1'b1;
                            end
                        end else begin
                            w_period_set = 1'b1;
                            w_consec_n   = '0;
                            w_locked_n   = 1'b0;
                        end
                    end else if (w_check_on && w_timeout) begin
                        // Leaving TRACK guarantees one report per gap.
                        w_missing_set = 1'b1;
                        w_consec_n    = '0;
                        w_locked_n    = 1'b0;
                        w_state_n     = ST_ACQUIRE;
                    end
                end

                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end

        // A new error in the same cycle as err_clear stays set.
        w_period_err_n  = w_period_set  | (r_period_err  & ~bus.err_clear);
        w_missing_err_n = w_missing_set | (r_missing_err & ~bus.err_clear);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_consec        <= '0;
            r_locked        <= 1'b0;
            r_period_err    <= 1'b0;
            r_missing_err   <= 1'b0;
            r_last_interval <= '0;
            r_start_count   <= '0;
            r_start_seen    <= 1'b0;
            r_user_period   <= '0;
        end else begin
            r_state         <= w_state_n;
            r_cnt           <= w_cnt_n;
            r_consec        <= w_consec_n;
            r_locked        <= w_locked_n;
            r_period_err    <= w_period_err_n;
            r_missing_err   <= w_missing_err_n;
            r_last_interval <= w_last_interval_n;
            r_start_count   <= w_start_count_n;
            r_start_seen    <= w_edge;
            r_user_period   <= bus.user_period;
        end
    end

    assign bus.start_seen    = r_start_seen;
    assign bus.locked        = r_locked;
    assign bus.period_err    = r_period_err;
    assign bus.missing_err   = r_missing_err;
    assign bus.last_interval = r_last_interval;
    assign bus.start_count   = r_start_count;

endmodule : start_monitor
`default_nettype wire

// File: tb/tb_start_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_start_monitor
// Description : Self-checking bench for start_monitor. Directed scenarios
//               followed by randomized pulse trains; every cycle the DUT
//               outputs are compared with an interval-arithmetic reference
//               model built on absolute cycle timestamps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_start_monitor;

    localparam int PS     = 2;
    localparam int CNT_W  = 16;
    localparam int TOL    = 1;
    localparam int LOCK_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    start_monitor_if #(.CNT_W(CNT_W)) bus ();

    start_monitor #(
        .PRESCALE_SHIFT (PS),
        .CNT_W          (CNT_W),
        .TOL            (TOL),
        .LOCK_N         (LOCK_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the time of the last reference edge and
    // derives intervals / deadlines as differences of cycle numbers.
    // ------------------------------------------------------------------
    longint    m_t = 0;
    bit        m_prev_in;
    bit [7:0]  m_up_prev;
    bit        m_active;      // enable was already seen on a previous cycle
    bit        m_have_ref;    // a reference edge exists for interval timing
    longint    m_ref_t;
    int        m_streak;
    bit        m_locked, m_perr, m_merr, m_seen;
    longint    m_last;
    int        m_count;

    task automatic model_reset();
        m_prev_in  = 1'b1;
        m_up_prev  = 8'd0;
        m_active   = 1'b0;
        m_have_ref = 1'b0;
        m_ref_t    = 0;
        m_streak   = 0;
        m_locked   = 1'b0;
        m_perr     = 1'b0;
        m_merr     = 1'b0;
        m_seen     = 1'b0;
        m_last     = 0;
        m_count    = 0;
    endtask

    task automatic model_step(input bit in_s, input bit [7:0] up, input bit en, input bit clr);
        bit     rise, changed, pset, mset;
        longint e, ival, dev;
        m_t++;
        rise      = in_s && !m_prev_in;
        m_prev_in = in_s;
        changed   = (up != m_up_prev);
        m_up_prev = up;
        e         = longint'(up) * (longint'(1) << PS);
        pset      = 1'b0;
        mset      = 1'b0;
        m_seen    = rise;
        if (!en) begin
            m_active   = 1'b0;
            m_have_ref = 1'b0;
            m_streak   = 0;
            m_locked   = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else begin
            if (rise) m_count = (m_count + 1) % 65536;
            if (!m_have_ref) begin
                if (rise) begin
                    m_have_ref = 1'b1;
                    m_ref_t    = m_t;
                end
            end else if (changed) begin
                m_have_ref = 1'b0;
                m_streak   = 0;
                m_locked   = 1'b0;
            end else if (rise) begin
                ival    = m_t - m_ref_t;
                m_ref_t = m_t;
                m_last  = ival;
                dev     = (ival > e) ? ival - e : e - ival;
                if (up == 8'd0) begin
                    m_streak = 0;
                    m_locked = 1'b0;
                end else if (dev <= TOL) begin
                    if (m_streak < LOCK_N) m_streak++;
                    if (m_streak == LOCK_N) m_locked = 1'b1;
                end else begin
                    pset     = 1'b1;
                    m_streak = 0;
                    m_locked = 1'b0;
                end
            end else if (up != 8'd0 && (m_t - m_ref_t) == e + TOL + 1) begin
                mset       = 1'b1;
                m_streak   = 0;
                m_locked   = 1'b0;
                m_have_ref = 1'b0;
            end
        end
        m_perr = pset | (m_perr & !clr);
        m_merr = mset | (m_merr & !clr);
    endtask

    task automatic compare_all();
        check_val("start_seen",    bus.start_seen,    m_seen);
        check_val("locked",        bus.locked,        m_locked);
        check_val("period_err",    bus.period_err,    m_perr);
        check_val("missing_err",   bus.missing_err,   m_merr);
        check_val("last_interval", bus.last_interval, m_last);
        check_val("start_count",   bus.start_count,   m_count);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit [7:0] cur_up = 8'd0;
    bit       cur_en = 1'b0;

    task automatic run_cycle(input bit in_s, input bit clr);
        bus.in_start    = in_s;
        bus.user_period = cur_up;
        bus.enable      = cur_en;
        bus.err_clear   = clr;
        @(posedge clk);
        model_step(in_s, cur_up, cur_en, clr);
        #1;
        compare_all();
    endtask

    // Edge occurs ival cycles after the previous one-cycle pulse.
    task automatic pulse_after(input int ival, input bit clr_on_edge);
        repeat (ival - 1) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, clr_on_edge);
    endtask

    task automatic seg(input int lows, input int highs);
        repeat (lows)  run_cycle(1'b0, ($urandom_range(0, 39) == 0));
        repeat (highs) run_cycle(1'b1, ($urandom_range(0, 39) == 0));
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_seen"},   bus.start_seen,    0);
        check_val({tag, "_locked"}, bus.locked,        0);
        check_val({tag, "_perr"},   bus.period_err,    0);
        check_val({tag, "_merr"},   bus.missing_err,   0);
        check_val({tag, "_last"},   bus.last_interval, 0);
        check_val({tag, "_count"},  bus.start_count,   0);
    endtask

    initial begin
        bus.in_start    = 1'b0;
        bus.user_period = 8'd0;
        bus.enable      = 1'b0;
        bus.err_clear   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Lock acquisition at E = 12.
        cur_en = 1'b1;
        cur_up = 8'd3;
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            pulse_after(12, 1'b0);
            if (i == 4) check_val("lock_not_yet", bus.locked, 0);
            if (i == 5) check_val("lock_after5", bus.locked, 1);
        end
        check_val("train_last", bus.last_interval, 12);
        check_val("train_count", bus.start_count, 6);

        // Tolerance edges, then an out-of-tolerance interval.
        pulse_after(13, 1'b0);
        pulse_after(11, 1'b0);
        check_val("tol_locked", bus.locked, 1);
        pulse_after(14, 1'b0);
        check_val("bad_perr", bus.period_err, 1);
        check_val("bad_locked", bus.locked, 0);
        check_val("bad_last", bus.last_interval, 14);
        run_cycle(1'b0, 1'b1);

        // Missing pulse and recovery.
        repeat (5) pulse_after(12, 1'b0);
        check_val("relock", bus.locked, 1);
        repeat (13) run_cycle(1'b0, 1'b0);
        check_val("miss_early", bus.missing_err, 0);
        run_cycle(1'b0, 1'b0);
        check_val("miss_set", bus.missing_err, 1);
        check_val("miss_locked", bus.locked, 0);
        repeat (5) run_cycle(1'b0, 1'b0);
        repeat (5) pulse_after(12, 1'b0);
        check_val("miss_relock", bus.locked, 1);
        check_val("miss_sticky", bus.missing_err, 1);
        run_cycle(1'b0, 1'b1);
        check_val("clr_merr", bus.missing_err, 0);

        // Period change while locked.
        cur_up = 8'd4;
        run_cycle(1'b0, 1'b0);
        check_val("chg_unlock", bus.locked, 0);
        repeat (14) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        repeat (4) pulse_after(16, 1'b0);
        check_val("chg_relock", bus.locked, 1);
        check_val("chg_noerr", bus.period_err | bus.missing_err, 0);

        // Clear coinciding with a new error, then clear alone.
        pulse_after(14, 1'b1);
        check_val("clr_vs_set", bus.period_err, 1);
        run_cycle(1'b0, 1'b1);
        check_val("clr_perr", bus.period_err, 0);

        // Checking disabled with user_period = 0.
        cur_up = 8'd0;
        repeat (5) pulse_after(5, 1'b0);
        check_val("up0_last", bus.last_interval, 5);
        check_val("up0_locked", bus.locked, 0);
        check_val("up0_err", bus.period_err | bus.missing_err, 0);

        // Asynchronous reset mid-TRACK, released with in_start high.
        cur_up = 8'd3;
        repeat (6) pulse_after(12, 1'b0);
        run_cycle(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_async");
        model_reset();
        bus.in_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) run_cycle(1'b1, 1'b0);
        check_val("rst_rel_seen", bus.start_seen, 0);

        // Randomized phase.
        for (int s = 0; s < 300; s++) begin
            int r, e, ival;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                cur_en = 1'b0;
                seg($urandom_range(1, 4), 0);
                cur_en = 1'b1;
            end else if (r < 9) begin
                cur_up = 8'($urandom_range(0, 5));
            end else if (r < 11) begin
                seg(1, $urandom_range(2, 30));
            end else begin
                e = (cur_up == 8'd0) ? 6 : int'(cur_up) * (1 << PS);
                if ($urandom_range(0, 19) == 0) ival = e + TOL + $urandom_range(1, 4);
                else ival = e + $urandom_range(0, 6) - 3;
                if (ival < 2) ival = 2;
                seg(ival - 1, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_start_monitor
`default_nettype wire
